// File: rtl/delay_tap_reader_if.sv
// Bus bundle for delay_tap_reader: write/control inputs and the tap outputs.
// The producer/consumer side uses the master modport. The delay block uses the slave modport.
interface delay_tap_reader_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data_in;
   logic             ce;
   logic             flush;
   logic [7:0]       out_pos;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic [7:0]       fill;
   logic             underrun;

   modport master (
      output data_in, ce, flush, out_pos,
      input  data_out, out_valid, fill, underrun
   );

   modport slave (
      input  data_in, ce, flush, out_pos,
      output data_out, out_valid, fill, underrun
   );
endinterface

// File: rtl/delay_tap_reader.sv
// delay_tap_reader: circular history buffer with a runtime-selectable read tap.
// Each ce writes one word at the head.
// Each ce also registers the word that is p ce-cycles old, where p is out_pos clamped to 1..DEPTH.
// Optional feature macro: DELAY_TAP_UNDERRUN_EN builds the sticky underrun flag.
// Without the macro, underrun is tied to 0.
module delay_tap_reader #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   delay_tap_reader_if.slave    bus
);
   localparam int         AW      = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [7:0]       fill_q;
   logic [WIDTH-1:0] dout_q;
   logic             vld_q;
   logic [7:0]       tap;
   logic [7:0]       lag;
   logic [AW-1:0]    rd_idx;
   logic [AW-1:0]    wr_nxt;
   logic             adv;

   assign adv = bus.ce && !bus.flush;

   // Clamp the requested tap into 1..DEPTH and derive how far behind the head to read
   always_comb begin
      tap = bus.out_pos;
      if (bus.out_pos == 8'd0)
         tap = 8'd1;
      else if (bus.out_pos > DEPTH_B)
         tap = DEPTH_B;
      lag = tap - 8'd1;
   end

   // Read index = (wr_ptr - lag) mod DEPTH using an explicit wrap compare.
   // The AW-bit modular math is exact because the result is always < DEPTH.
   always_comb begin
      if (8'(wr_ptr) >= lag)
         rd_idx = wr_ptr - AW'(lag);
      else
         rd_idx = wr_ptr + AW'(DEPTH) - AW'(lag);
      wr_nxt = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
   end

   // Storage array, not reset.
   // The tap read samples the old contents because all updates are non-blocking.
   always_ff @(posedge clk) begin
      if (reset && adv)
         mem[wr_ptr] <= bus.data_in;
   end

   // Head pointer, fill level and registered tap output
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         fill_q <= 8'd0;
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         fill_q <= 8'd0;
         vld_q  <= 1'b0;
      end else if (bus.ce) begin
         wr_ptr <= wr_nxt;
         fill_q <= (fill_q == DEPTH_B) ? DEPTH_B : fill_q + 8'd1;
         dout_q <= (tap == 8'd1) ? bus.data_in : mem[rd_idx];
         vld_q  <= (fill_q >= lag);
      end else begin
         vld_q  <= 1'b0;
      end
   end

`ifdef DELAY_TAP_UNDERRUN_EN
   logic under_q;

   // Sticky flag: a tap reached past stored history; cleared only by flush or reset
   always_ff @(posedge clk) begin
      if (!reset || bus.flush)
         under_q <= 1'b0;
      else if (bus.ce && (fill_q < lag))
         under_q <= 1'b1;
   end

   assign bus.underrun = under_q;
`else
   assign bus.underrun = 1'b0;
`endif

   assign bus.data_out  = dout_q;
   assign bus.out_valid = vld_q;
   assign bus.fill      = fill_q;
endmodule

// File: tb/tb_delay_tap_reader.sv
// Self-checking bench for delay_tap_reader (DEPTH=4, WIDTH=32).
// The bench uses a directed vector table, hand-written multi-cycle sequences and a randomized run.
// All phases are checked against a word-history queue model.
module tb_delay_tap_reader;
   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
`ifdef DELAY_TAP_UNDERRUN_EN
   localparam logic UND = 1'b1;
`else
   localparam logic UND = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   delay_tap_reader_if #(.WIDTH(WIDTH)) bus ();

   delay_tap_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, c, f;
      logic [7:0]  pos;
      logic [31:0] din;
      logic        ev;
      logic [31:0] ed;
      logic        cd;
      logic [7:0]  ef;
      logic        eu;
   } vec_t;

   vec_t tbl[$];

   // Reference model: the words written since the last flush/reset, newest at the back
   logic [31:0] hist[$];
   logic        m_valid, m_known, m_under;
   logic [31:0] m_dout;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic c, input logic f,
                        input logic [7:0] pos, input logic [31:0] din);
      int p, fp;
      reset       = r;
      bus.ce      = c;
      bus.flush   = f;
      bus.out_pos = pos;
      bus.data_in = din;
      if (!r) begin
         hist.delete();
         m_valid = 0; m_dout = 0; m_known = 1; m_under = 0;
      end else if (f) begin
         hist.delete();
         m_valid = 0; m_under = 0;
      end else if (c) begin
         p  = (pos == 0) ? 1 : (int'(pos) > DEPTH) ? DEPTH : int'(pos);
         fp = hist.size();
         m_valid = (fp >= p - 1);
         if (!m_valid && UND) m_under = 1;
         if (p == 1) begin
            m_dout = din; m_known = 1;
         end else if (m_valid) begin
            m_dout = hist[fp - (p - 1)]; m_known = 1;
         end else begin
            m_known = 0;
         end
         hist.push_back(din);
         if (hist.size() > DEPTH) void'(hist.pop_front());
      end else begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
      check("model_valid", 32'(bus.out_valid), 32'(m_valid));
      check("model_fill", 32'(bus.fill), 32'(hist.size()));
      check("model_underrun", 32'(bus.underrun), 32'(m_under));
      if (m_known) check("model_data_out", bus.data_out, m_dout);
   endtask

   task automatic add(input logic r, input logic c, input logic f, input logic [7:0] pos,
                      input logic [31:0] din, input logic ev, input logic [31:0] ed,
                      input logic cd, input logic [7:0] ef, input logic eu);
      vec_t v;
      v = '{r: r, c: c, f: f, pos: pos, din: din, ev: ev, ed: ed, cd: cd, ef: ef, eu: eu};
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b0; bus.ce = 0; bus.flush = 0; bus.out_pos = 8'd4; bus.data_in = '0;
      hist.delete(); m_valid = 0; m_dout = 0; m_known = 1; m_under = 0;
      #2;

      // Directed table: reset, tap 4 stream, tap 1 stream, clamp cases, flush with ce
      add(0,0,0,8'd4,32'h0,   0,32'h0,1,8'd0,0);
      add(1,1,0,8'd4,32'h1,   0,32'h0,0,8'd1,UND);
      add(1,1,0,8'd4,32'h2,   0,32'h0,0,8'd2,UND);
      add(1,1,0,8'd4,32'h3,   0,32'h0,0,8'd3,UND);
      add(1,1,0,8'd4,32'h4,   1,32'h1,1,8'd4,UND);
      add(1,1,0,8'd4,32'h5,   1,32'h2,1,8'd4,UND);
      add(1,1,0,8'd4,32'h6,   1,32'h3,1,8'd4,UND);
      add(0,0,0,8'd1,32'h0,   0,32'h0,1,8'd0,0);
      add(1,1,0,8'd1,32'hA,   1,32'hA,1,8'd1,0);
      add(1,1,0,8'd1,32'hB,   1,32'hB,1,8'd2,0);
      add(1,1,0,8'd1,32'hC,   1,32'hC,1,8'd3,0);
      add(1,1,0,8'd0,32'hD,   1,32'hD,1,8'd4,0);
      add(1,1,0,8'd9,32'hE,   1,32'hB,1,8'd4,0);
      add(1,1,1,8'd4,32'h7,   0,32'hB,1,8'd0,0);
      add(1,1,0,8'd1,32'h8,   1,32'h8,1,8'd1,0);
      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].c, tbl[i].f, tbl[i].pos, tbl[i].din);
         check($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
         check($sformatf("tbl%0d_fill", i), 32'(bus.fill), 32'(tbl[i].ef));
         check($sformatf("tbl%0d_underrun", i), 32'(bus.underrun), 32'(tbl[i].eu));
         if (tbl[i].cd) check($sformatf("tbl%0d_data_out", i), bus.data_out, tbl[i].ed);
      end

      // ce gated low for 3 cycles: output held, no pulse, stream resumes without skipping
      apply(0,0,0,8'd2,32'h0);
      for (int k = 0; k < 4; k++) apply(1,1,0,8'd2,32'h10 + 32'(k));
      for (int k = 0; k < 3; k++) begin
         apply(1,0,0,8'd2,32'hDEAD);
         check("gate_hold_data", bus.data_out, 32'h12);
         check("gate_valid_low", 32'(bus.out_valid), 32'h0);
         check("gate_fill", 32'(bus.fill), 32'd4);
      end
      apply(1,1,0,8'd2,32'h14);
      check("gate_resume_data", bus.data_out, 32'h13);
      check("gate_resume_valid", 32'(bus.out_valid), 32'h1);

      // Flush with ce drops the word, then refilling reaches tap 4 only on the 4th ce
      apply(0,0,0,8'd4,32'h0);
      for (int k = 0; k < 3; k++) apply(1,1,0,8'd4,32'h21 + 32'(k));
      apply(1,1,1,8'd4,32'h7);
      check("flush_fill", 32'(bus.fill), 32'd0);
      check("flush_valid", 32'(bus.out_valid), 32'h0);
      for (int k = 0; k < 4; k++) begin
         apply(1,1,0,8'd4,32'h31 + 32'(k));
         check($sformatf("refill%0d_valid", k), 32'(bus.out_valid), (k == 3) ? 32'h1 : 32'h0);
      end
      check("refill_data", bus.data_out, 32'h31);

      // Underrun is sticky until flush
      apply(0,0,0,8'd3,32'h0);
      apply(1,1,0,8'd3,32'h41);
      check("underrun_set", 32'(bus.underrun), 32'(UND));
      apply(1,0,0,8'd3,32'h0);
      apply(1,0,0,8'd3,32'h0);
      check("underrun_hold", 32'(bus.underrun), 32'(UND));
      apply(1,0,1,8'd3,32'h0);
      check("underrun_clear", 32'(bus.underrun), 32'h0);

      // Randomized traffic against the history model
      apply(0,0,0,8'd1,32'h0);
      for (int k = 0; k < 600; k++) begin
         apply(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 19) == 0),
               8'($urandom_range(0, 9)),
               $urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
